// File: rtl/lcd_bus_responder.sv
// -----------------------------------------------------------------------------
// lcd_bus_responder
//   Responder end of the 8-bit HD44780-style LCD bus (data/rs/rw/en). It
//   decodes instruction and data strobes on the falling edge of en, keeps a
//   DDRAM character buffer, a cursor, the entry-mode direction and a busy
//   flag, and answers busy-flag and data reads.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   data        bus data from the controller
//   rs, rw, en  register select, read/not-write, enable strobe
//   data_out    read data returned to the bus (0 when not reading)
//   data_oe     data_out is being driven
//   busy        busy flag
//   cursor      current DDRAM address
//   display_on  display-control D bit
//   char_valid  one-cycle pulse per accepted character write
//   char_out    character written (with char_valid)
//   char_addr   address written (with char_valid)
//   rd_addr     side-port DDRAM read address
//   rd_char     ddram[rd_addr], one cycle latency
//
// Optional build macro LCD_RESP_ERRCNT_EN adds:
//   err_cnt     saturating count of write strobes dropped while busy
//   err_pulse   one-cycle pulse per dropped write strobe
// -----------------------------------------------------------------------------
module lcd_bus_responder #(
  parameter int DEPTH       = 32,
  parameter int AW          = 5,
  parameter int EXEC_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    data,
  input  logic          rs,
  input  logic          rw,
  input  logic          en,
  output logic [7:0]    data_out,
  output logic          data_oe,
  output logic          busy,
  output logic [AW-1:0] cursor,
  output logic          display_on,
  output logic          char_valid,
  output logic [7:0]    char_out,
  output logic [AW-1:0] char_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char
`ifdef LCD_RESP_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt,
  output logic          err_pulse
`endif
);

  // Counter only needs to hold EXEC_CYCLES-1.
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [AW-1:0]  clr_idx_r, clr_idx_s;

  logic           en_q_r, rs_q_r, rw_q_r;
  logic [7:0]     data_q_r;

  logic [7:0]     ddram [DEPTH];

  logic [AW-1:0]  cursor_r;
  logic           id_r;
  logic           display_on_r;
  logic           busy_r;
  logic           char_valid_r;
  logic [7:0]     char_out_r;
  logic [AW-1:0]  char_addr_r;
  logic           data_oe_r;
  logic [7:0]     data_out_r;
  logic [7:0]     rd_char_r;

  logic           strobe_s, wr_strobe_s, wr_accept_s, wr_drop_s;
  logic           rd_strobe_s, is_clear_s, clr_done_s, data_wr_s;

  // Step the cursor one cell up or down; wraps modulo DEPTH via AW bits.
  function automatic logic [AW-1:0] cursor_step(input logic [AW-1:0] c,
                                                input logic up);
    if (up) begin
      return c + AW'(1);
    end else begin
      return c - AW'(1);
    end
  endfunction

  // The rs/rw/data registers still hold the last en=1 cycle when the edge is seen.
  assign strobe_s    = en_q_r & ~en;
  assign wr_strobe_s = strobe_s & ~rw_q_r;
  assign wr_accept_s = wr_strobe_s & (state_r == ST_IDLE);
  assign wr_drop_s   = wr_strobe_s & (state_r != ST_IDLE);
  assign rd_strobe_s = strobe_s & rw_q_r & rs_q_r;
  assign is_clear_s  = ~rs_q_r & (data_q_r == 8'h01);
  assign clr_done_s  = (state_r == ST_CLEAR) & (clr_idx_r == AW'(DEPTH - 1));
  assign data_wr_s   = wr_accept_s & rs_q_r;

  // Next-state logic for the IDLE/EXEC/CLEAR controller.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    clr_idx_s = clr_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_accept_s) begin
          if (is_clear_s) begin
            state_s   = ST_CLEAR;
            clr_idx_s = '0;
          end else begin
            state_s = ST_EXEC;
            cnt_s   = CW'(EXEC_CYCLES - 1);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == '0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      ST_CLEAR: begin
        if (clr_done_s) begin
          state_s = ST_IDLE;
        end else begin
          clr_idx_s = clr_idx_r + AW'(1);
        end
      end
      default: begin
        state_s   = ST_CLEAR;
        clr_idx_s = '0;
      end
    endcase
  end

  // Controller state register; busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_CLEAR;
      cnt_r     <= '0;
      clr_idx_r <= '0;
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      clr_idx_r <= clr_idx_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // DDRAM write port: clear sweep or accepted character write (never both).
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_r == ST_CLEAR) begin
        ddram[clr_idx_r] <= 8'h20;
      end else if (data_wr_s) begin
        ddram[cursor_r] <= data_q_r;
      end
    end
  end

  // Side-port read, registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_char_r <= 8'h00;
    end else begin
      rd_char_r <= ddram[rd_addr];
    end
  end

  // Bus sampling, read response, cursor/mode state and character events.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q_r       <= 1'b0;
      rs_q_r       <= 1'b0;
      rw_q_r       <= 1'b0;
      data_q_r     <= 8'h00;
      cursor_r     <= '0;
      id_r         <= 1'b1;
      display_on_r <= 1'b0;
      char_valid_r <= 1'b0;
      char_out_r   <= 8'h00;
      char_addr_r  <= '0;
      data_oe_r    <= 1'b0;
      data_out_r   <= 8'h00;
    end else begin
      en_q_r       <= en;
      rs_q_r       <= rs;
      rw_q_r       <= rw;
      data_q_r     <= data;
      char_valid_r <= 1'b0;
      data_oe_r    <= en & rw;
      if (en & rw) begin
        data_out_r <= rs ? ddram[cursor_r] : {busy_r, 7'(cursor_r)};
      end else begin
        data_out_r <= 8'h00;
      end

      // End of a clear wins over a read strobe landing on the same edge.
      if (clr_done_s) begin
        cursor_r <= '0;
        id_r     <= 1'b1;
      end else if (data_wr_s) begin
        char_valid_r <= 1'b1;
        char_out_r   <= data_q_r;
        char_addr_r  <= cursor_r;
        cursor_r     <= cursor_step(cursor_r, id_r);
      end else if (wr_accept_s) begin
        // Instruction decoded by its highest set bit. Only the observable
        // bits (entry direction, display D bit, cursor) are kept.
        casez (data_q_r)
          8'b1???????: cursor_r <= data_q_r[AW-1:0];
          8'b0001????: begin
            if (!data_q_r[3]) begin
              cursor_r <= cursor_step(cursor_r, data_q_r[2]);
            end else begin
              cursor_r <= cursor_r;
            end
          end
          8'b00001???: display_on_r <= data_q_r[2];
          8'b000001??: id_r <= data_q_r[1];
          8'b0000001?: cursor_r <= '0;
          default: cursor_r <= cursor_r;
        endcase
      end else if (rd_strobe_s) begin
        cursor_r <= cursor_step(cursor_r, id_r);
      end
    end
  end

`ifdef LCD_RESP_ERRCNT_EN
  logic [7:0] err_cnt_r;
  logic       err_pulse_r;

  // Saturating count of write strobes dropped while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_r   <= 8'h00;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= wr_drop_s;
      if (wr_drop_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'h01;
      end
    end
  end

  assign err_cnt   = err_cnt_r;
  assign err_pulse = err_pulse_r;
`endif

  assign data_out   = data_out_r;
  assign data_oe    = data_oe_r;
  assign busy       = busy_r;
  assign cursor     = cursor_r;
  assign display_on = display_on_r;
  assign char_valid = char_valid_r;
  assign char_out   = char_out_r;
  assign char_addr  = char_addr_r;
  assign rd_char    = rd_char_r;

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int EXEC_CYCLES = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic rs = 1'b0, rw = 1'b0, en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0] data_out, char_out, rd_char;
  logic data_oe, busy, display_on, char_valid;
  logic [AW-1:0] cursor, char_addr;
`ifdef LCD_RESP_ERRCNT_EN
  logic [7:0] err_cnt;
  logic err_pulse;
`endif

  lcd_bus_responder #(.DEPTH(DEPTH), .AW(AW), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .reset(reset), .data(data), .rs(rs), .rw(rw), .en(en),
    .data_out(data_out), .data_oe(data_oe), .busy(busy), .cursor(cursor),
    .display_on(display_on), .char_valid(char_valid), .char_out(char_out),
    .char_addr(char_addr), .rd_addr(rd_addr), .rd_char(rd_char)
`ifdef LCD_RESP_ERRCNT_EN
    , .err_cnt(err_cnt), .err_pulse(err_pulse)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit rand_rd = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (spec-level) ----------------
  logic [7:0] m_mem [DEPTH];
  bit   m_known [DEPTH];
  int   m_cursor = 0;
  bit   m_id = 1, m_disp = 0;
  int   m_exec_left = 0;
  bit   m_clearing = 1;
  int   m_clr_pos = 0;
  bit   m_prev_en = 0;
  bit   m_lrs = 0, m_lrw = 0;
  logic [7:0] m_ld = 8'h00;
  bit   e_valid = 0;
  bit   e_busy = 1, e_cv = 0, e_oe = 0, e_rd_known = 0, e_dout_known = 0, e_errp = 0;
  logic [7:0] e_cout = 8'h00, e_dout = 8'h00, e_rdchar = 8'h00;
  int   e_caddr = 0, e_err = 0;

  task automatic model_step();
    bit busy_now, strobe, clear_end;
    int hb;
    if (!reset) begin
      e_valid = 1; e_busy = 1; m_cursor = 0; m_id = 1; m_disp = 0;
      e_cv = 0; e_oe = 0; e_dout = 8'h00; e_dout_known = 1;
      e_rdchar = 8'h00; e_rd_known = 1; m_clearing = 1; m_clr_pos = 0;
      m_exec_left = 0; m_prev_en = 0; e_err = 0; e_errp = 0;
    end else begin
      busy_now = e_busy;
      e_oe = en && rw;
      if (en && rw) begin
        if (rs) begin
          e_dout = m_mem[m_cursor]; e_dout_known = m_known[m_cursor];
        end else begin
          e_dout = (busy_now ? 8'h80 : 8'h00) | 8'(m_cursor); e_dout_known = 1;
        end
      end else begin
        e_dout = 8'h00; e_dout_known = 1;
      end
      e_rdchar = m_mem[rd_addr]; e_rd_known = m_known[rd_addr];
      e_cv = 0; e_errp = 0; clear_end = 0;
      strobe = m_prev_en && !en;
      if (m_clearing) begin
        m_mem[m_clr_pos] = 8'h20; m_known[m_clr_pos] = 1; m_clr_pos++;
        if (m_clr_pos == DEPTH) begin m_clearing = 0; clear_end = 1; end
      end else if (m_exec_left > 0) begin
        m_exec_left--;
      end
      if (strobe) begin
        if (!m_lrw) begin
          if (busy_now) begin
            e_errp = 1;
            if (e_err < 255) e_err++;
          end else if (m_lrs) begin
            m_mem[m_cursor] = m_ld; m_known[m_cursor] = 1;
            e_cv = 1; e_cout = m_ld; e_caddr = m_cursor;
            m_cursor = (m_cursor + (m_id ? 1 : DEPTH - 1)) % DEPTH;
            m_exec_left = EXEC_CYCLES;
          end else if (m_ld == 8'h01) begin
            m_clearing = 1; m_clr_pos = 0;
          end else begin
            m_exec_left = EXEC_CYCLES;
            hb = -1;
            for (int b = 0; b < 8; b++) if (m_ld[b]) hb = b;
            case (hb)
              7: m_cursor = m_ld % DEPTH;
              4: if (!m_ld[3]) m_cursor = (m_cursor + (m_ld[2] ? 1 : DEPTH - 1)) % DEPTH;
              3: m_disp = m_ld[2];
              2: m_id = m_ld[1];
              1: m_cursor = 0;
              default: ;
            endcase
          end
        end else if (m_lrs) begin
          m_cursor = (m_cursor + (m_id ? 1 : DEPTH - 1)) % DEPTH;
        end
      end
      if (clear_end) begin m_cursor = 0; m_id = 1; end
      e_busy = m_clearing || (m_exec_left > 0);
      m_prev_en = en;
      if (en) begin m_lrs = rs; m_lrw = rw; m_ld = data; end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every registered output against the model.
  initial forever begin
    @(negedge clk);
    if (e_valid) begin
      chk("busy", busy, e_busy);
      chk("cursor", cursor, m_cursor);
      chk("display_on", display_on, m_disp);
      chk("char_valid", char_valid, e_cv);
      if (e_cv) begin
        chk("char_out", char_out, e_cout);
        chk("char_addr", char_addr, e_caddr);
      end
      chk("data_oe", data_oe, e_oe);
      if (e_dout_known) chk("data_out", data_out, e_dout);
      if (e_rd_known) chk("rd_char", rd_char, e_rdchar);
`ifdef LCD_RESP_ERRCNT_EN
      chk("err_cnt", err_cnt, e_err);
      chk("err_pulse", err_pulse, e_errp);
`endif
    end
  end

  always @(negedge clk) if (rand_rd) rd_addr = AW'($urandom);

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic bus_op(input bit r_s, input bit r_w, input logic [7:0] d, input int hold,
                        output logic [7:0] dout_seen, output bit oe_seen);
    rs = r_s; rw = r_w; data = d; en = 1'b1;
    @(negedge clk);
    dout_seen = data_out; oe_seen = data_oe;
    for (int i = 1; i < hold; i++) @(negedge clk);
    en = 1'b0; rs = 1'($urandom); rw = 1'($urandom); data = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic wr(input bit r_s, input logic [7:0] d);
    logic [7:0] dd; bit oo;
    bus_op(r_s, 1'b0, d, 1, dd, oo);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("idle_reached", busy, 0);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
  endtask

  task automatic check_all_blank();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      @(negedge clk);
      chk("blank_cell", rd_char, 8'h20);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [7:0] dseen;
    bit oseen;

    // Reset held 3 cycles, then the power-up clear.
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1);
    chk("reset_cursor", cursor, 0);
    chk("reset_oe", data_oe, 0);
    reset = 1'b1;
    count_busy(cnt);
    chk("powerup_busy_cycles", cnt, 32);
    chk("powerup_cursor", cursor, 0);
    check_all_blank();

    // "Hi" at address 0.
    wr(1'b0, 8'h80); wait_idle();
    wr(1'b1, 8'h48);
    chk("H_valid", char_valid, 1); chk("H_char", char_out, 8'h48); chk("H_addr", char_addr, 0);
    wait_idle();
    wr(1'b1, 8'h69);
    chk("i_valid", char_valid, 1); chk("i_char", char_out, 8'h69); chk("i_addr", char_addr, 1);
    wait_idle();
    chk("cursor_after_Hi", cursor, 2);
    rd_addr = 5'd1; @(negedge clk);
    chk("rd_char_1", rd_char, 8'h69);

    // Wrap up at 31, then decrement mode wrapping down from 0.
    wr(1'b0, 8'h9F); wait_idle();
    wr(1'b1, 8'h41);
    chk("A_addr", char_addr, 31); chk("A_wrap_cursor", cursor, 0);
    wait_idle();
    wr(1'b0, 8'h04); wait_idle();
    wr(1'b1, 8'h42);
    chk("B_addr", char_addr, 0); chk("B_wrap_cursor", cursor, 31);

    // Busy-flag read while still busy, then data read at cursor 0.
    bus_op(1'b0, 1'b1, 8'h00, 2, dseen, oseen);
    chk("bf_read_oe", oseen, 1); chk("bf_read_data", dseen, 8'h9F);
    wait_idle();
    wr(1'b0, 8'h80); wait_idle();
    bus_op(1'b1, 1'b1, 8'h00, 1, dseen, oseen);
    chk("data_read_oe", oseen, 1); chk("data_read", dseen, 8'h42);
    chk("read_cursor_dec", cursor, 31);

    // Display on, then clear with a dropped write in the middle.
    wr(1'b0, 8'h0C); wait_idle();
    chk("display_on", display_on, 1);
    wr(1'b0, 8'h01);
    count_busy(cnt);
    chk("clear_busy_cycles", cnt, 32);
    chk("clear_cursor", cursor, 0);
    check_all_blank();
    wr(1'b0, 8'h01);
    repeat (5) @(negedge clk);
    wr(1'b1, 8'h5A);
    chk("drop_no_char", char_valid, 0);
    wait_idle();
`ifdef LCD_RESP_ERRCNT_EN
    chk("err_cnt_one", err_cnt, 1);
`endif
    rd_addr = 5'd0; @(negedge clk);
    chk("drop_cell0_blank", rd_char, 8'h20);

    // Reset two cycles after a data write.
    wr(1'b1, 8'h51);
    chk("Q_valid", char_valid, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mid_exec_cv", char_valid, 0);
    reset = 1'b1;
    count_busy(cnt);
    chk("reset_mid_exec_busy", cnt, 32);
    rd_addr = 5'd0; @(negedge clk);
    chk("reset_mid_exec_cell0", rd_char, 8'h20);

    // Randomised traffic against the model.
    rand_rd = 1;
    for (int it = 0; it < 300; it++) begin
      bit r_s, r_w;
      logic [7:0] d;
      r_w = ($urandom_range(0, 99) < 25);
      r_s = 1'($urandom);
      d = 8'($urandom);
      if (!r_s && !r_w) begin
        if (d == 8'h00) d = 8'h06;
        if (d == 8'h01 && $urandom_range(0, 3) != 0) d = 8'h87;
      end
      bus_op(r_s, r_w, d, $urandom_range(1, 3), dseen, oseen);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        reset = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rd = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
